// File: rtl/sub_bytes_seq.sv
// Iterative forward AES SubBytes unit.
// Each block takes 16/BYTES_PER_CYCLE busy cycles: one chunk of BYTES_PER_CYCLE
// bytes is substituted per clock, in place, inside the state register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high and ready is low.
// in_ready is high only in IDLE and out_valid only in DONE, so an input accept
// and an output transfer never share a cycle.
module sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box, row-major by high nibble.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [127:0]    data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Byte 0 is the MSB byte, so chunk c lives in the packed element NCHUNK-1-c.
  logic [NCHUNK-1:0][8*BYTES_PER_CYCLE-1:0] chunks, chunks_next;
  logic [CW-1:0]                            chunk_idx;
  logic [BYTES_PER_CYCLE-1:0][7:0]          cur_chunk, sub_chunk;

  assign chunks    = data_q;
  assign chunk_idx = CW'(NCHUNK - 1) - cnt_q;
  assign cur_chunk = chunks[chunk_idx];

  // One S-box lookup per lane; lane j handles byte j of the current chunk.
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign sub_chunk[BYTES_PER_CYCLE-1-j] = SBOX[cur_chunk[BYTES_PER_CYCLE-1-j]];
  end

  // Merge the substituted chunk back into the full state.
  always_comb begin
    chunks_next            = chunks;
    chunks_next[chunk_idx] = sub_chunk;
  end

  // State, data and chunk counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy   = 1'b1;
        data_d = chunks_next;
        // The counter parks on the last chunk rather than wrapping.
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: default instance with directed and random traffic,
// plus instances at the other legal widths running exhaustive byte coverage.
module tb_sub_bytes_seq;

  localparam int BPC    = 4;
  localparam int NCHUNK = 16 / BPC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n     = 1'b0;
  logic aux_rst_n = 1'b0;

  // ---------------- default DUT ----------------
  logic [127:0] in_data  = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;

  sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [7:0] ref_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w = {b, b};
    return w[15-n -: 8];
  endfunction

  // Multiplicative inverse as a^254, then the affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ref_tab[i] = sbox_calc(8'(i));
  end

  function automatic logic [127:0] sub_ref(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = ref_tab[x[127-8*i -: 8]];
    return y;
  endfunction

  function automatic logic [127:0] seq_block(input int k);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = 8'(16*k + i);
    return b;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout_or_missing expected=event t=%0t", name, $time);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [127:0] exp_q[$];
  int           acc_q[$];
  bit           seen   = 1'b0;
  int           hs_cnt = 0;

  // Pushes on accept, pops on output transfer; sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(sub_ref(in_data));
        acc_q.push_back(cyc + 1);
      end
      if (out_valid) begin
        check("no_overlap_in_ready", 128'(in_ready), 128'(0));
        if (!seen) begin
          seen = 1'b1;
          if (acc_q.size() == 0) fail_now("valid_without_accept");
          else check("latency", 128'(cyc + 1 - acc_q[0]), 128'(NCHUNK + 1));
        end
        if (out_ready) begin
          seen = 1'b0;
          hs_cnt++;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            check("out_data", out_data, exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  bit rand_ready  = 1'b0;
  bit ready_force = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_force;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [127:0] d);
    int n = 0;
    @(posedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("send_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now(name);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now(name);
    @(posedge clk); #1;
  endtask

  // ---------------- other widths ----------------
  for (genvar g = 0; g < 4; g++) begin : g_aux
    localparam int P  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    localparam int NC = 16 / P;

    logic [127:0] a_in_data  = '0;
    logic         a_in_valid = 1'b0;
    logic         a_in_ready;
    logic [127:0] a_out_data;
    logic         a_out_valid;
    logic         a_out_ready = 1'b0;
    logic         a_busy;
    logic [127:0] a_exp_q[$];
    int           a_acc_q[$];
    bit           a_seen = 1'b0;
    int           a_got  = 0;
    bit           a_done = 1'b0;

    sub_bytes_seq #(.BYTES_PER_CYCLE(P)) u_dut (
      .clk       (clk),
      .rst_n     (aux_rst_n),
      .in_data   (a_in_data),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .out_data  (a_out_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .busy      (a_busy)
    );

    always @(posedge clk) begin
      #1;
      a_out_ready = ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
      if (aux_rst_n) begin
        if (a_in_valid && a_in_ready) begin
          a_exp_q.push_back(sub_ref(a_in_data));
          a_acc_q.push_back(cyc + 1);
        end
        if (a_out_valid) begin
          if (!a_seen) begin
            a_seen = 1'b1;
            if (a_acc_q.size() == 0) fail_now($sformatf("aux%0d_valid_without_accept", P));
            else check($sformatf("aux%0d_latency", P), 128'(cyc + 1 - a_acc_q[0]), 128'(NC + 1));
          end
          if (a_out_ready) begin
            a_seen = 1'b0;
            if (a_exp_q.size() == 0) begin
              fail_now($sformatf("aux%0d_unexpected_output", P));
            end else begin
              check($sformatf("aux%0d_out_data", P), a_out_data, a_exp_q.pop_front());
              void'(a_acc_q.pop_front());
              a_got++;
            end
          end
        end
      end
    end

    task automatic a_send(input logic [127:0] d);
      int n = 0;
      @(posedge clk); #1;
      a_in_data  = d;
      a_in_valid = 1'b1;
      @(negedge clk);
      while (!a_in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!a_in_ready) fail_now($sformatf("aux%0d_send_accept", P));
      @(posedge clk); #1;
      a_in_valid = 1'b0;
    endtask

    initial begin
      int n = 0;
      wait (aux_rst_n);
      for (int k = 0; k < 16; k++) a_send(seq_block(k));
      for (int k = 0; k < 4; k++) a_send(rand_block());
      while (a_got < 20 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (a_got < 20) fail_now($sformatf("aux%0d_drain", P));
      a_done = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (60000) @(posedge clk);
    fail_now("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] held;
    int           h0;
    int           prev;
    int           acc;
    int           nacc;
    int           guard;

    #23 aux_rst_n = 1'b1;

    // Reset values.
    @(negedge clk);
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_out_data",  out_data,        128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All-zero block.
    send('0);
    check("in_ready_drop", 128'(in_ready), 128'(0));
    check("busy_high",     128'(busy),     128'(1));
    wait_out_valid("zero_out_valid");
    check("zero_block", out_data, {16{8'h63}});
    @(posedge clk); #1;
    check("idle_after_hs_in_ready",  128'(in_ready),  128'(1));
    check("idle_after_hs_out_valid", 128'(out_valid), 128'(0));

    // Anchor bytes, checking byte order and chunk boundaries.
    send(128'h00015253c9ff00000000000000000000);
    wait_out_valid("anchor_out_valid");
    check("anchor", out_data, 128'h637c00eddd1663636363636363636363);
    @(posedge clk); #1;

    // Exhaustive 00..ff under random backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 16; k++) send(seq_block(k));
    rand_ready = 1'b0;
    drain("exhaustive_drain");

    // Backpressure hold.
    ready_force = 1'b0;
    send(rand_block());
    wait_out_valid("bp_out_valid");
    held = out_data;
    h0   = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 3);
      in_data  = rand_block();
      @(negedge clk);
      check("bp_out_valid_hold", 128'(out_valid), 128'(1));
      check("bp_out_data_hold",  out_data,        held);
      check("bp_in_ready_low",   128'(in_ready),  128'(0));
      check("bp_busy_low",       128'(busy),      128'(0));
    end
    @(posedge clk); #1;
    in_valid    = 1'b0;
    ready_force = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("bp_one_transfer", 128'(hs_cnt - h0), 128'(1));
    check("bp_no_capture",   128'(exp_q.size()), 128'(0));

    // Reset two cycles into BUSY.
    send(rand_block());
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  128'(in_ready),  128'(1));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_busy",      128'(busy),      128'(0));
    check("mid_rst_out_data",  out_data,        128'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready",  128'(in_ready),  128'(1));
    check("post_rst_out_valid", 128'(out_valid), 128'(0));
    send(rand_block());
    drain("post_rst_drain");

    // Back-to-back with in_valid and out_ready held high; data changes while busy.
    prev  = -1;
    nacc  = 0;
    guard = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = rand_block();
    while (nacc < 8 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        acc = cyc + 1;
        if (prev >= 0) check("b2b_spacing", 128'(acc - prev), 128'(NCHUNK + 2));
        prev = acc;
        nacc++;
        @(posedge clk); #1;
        in_data = rand_block();
        if (nacc == 8) in_valid = 1'b0;
      end
    end
    if (nacc < 8) fail_now("b2b_accepts");
    in_valid = 1'b0;
    drain("b2b_drain");

    // Random blocks, random gaps, random backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(rand_block());
    end
    rand_ready = 1'b0;
    drain("random_drain");

    // Wait for the other-width instances.
    guard = 0;
    while (!(g_aux[0].a_done && g_aux[1].a_done && g_aux[2].a_done && g_aux[3].a_done)
           && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!(g_aux[0].a_done && g_aux[1].a_done && g_aux[2].a_done && g_aux[3].a_done))
      fail_now("aux_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
